// File: rtl/rom_load_arbiter.sv
// Program-ROM arbiter: time-slices the single-port ROM between MCU fetch and a host
// loader, owns the divide-by-4 MCU phase and sequences downloads with the MCU in reset.
module rom_load_arbiter #(
  parameter int AW       = 11,
  parameter int DW       = 8,
  parameter int ROM_SIZE = 2048,
  parameter int HOLD     = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  output logic [DW-1:0] cpu_data,
  output logic          cpu_en,
  output logic          cpu_reset,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  input  logic          dl_start,
  input  logic          dl_end,
  input  logic          dl_valid,
  input  logic [AW-1:0] dl_addr,
  input  logic [DW-1:0] dl_data,
  output logic          dl_ready,
  output logic          dl_done,
  output logic [11:0]   dl_count,
  output logic [7:0]    dl_sum,
  output logic          dl_err
);

  localparam int HW = $clog2(HOLD + 1);
  localparam logic [HW-1:0] HoldLast = HW'(HOLD - 1);
  localparam logic [AW:0]   RomLimit = (AW + 1)'(ROM_SIZE);

  typedef enum logic [1:0] {StRun, StLoad, StHold} state_e;

  state_e          state_q, state_d;
  logic [1:0]      phase_q;
  logic [HW-1:0]   hold_q, hold_d;
  logic [DW-1:0]   cpu_data_q;
  logic [11:0]     count_q, count_d, count_base;
  logic [7:0]      sum_q, sum_d, sum_base;
  logic            err_q, err_d;
  logic            in_range;
  logic            accept;
  logic            hold_end;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    dl_ready  = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = dl_data;
    mem_we    = 1'b0;
    cpu_en    = 1'b0;
    cpu_reset = 1'b1;
    dl_done   = 1'b0;
    in_range  = ({1'b0, dl_addr} < RomLimit);
    hold_end  = (hold_q == HoldLast) && (phase_q == 2'd3);

    unique case (state_q)
      StRun: begin
        cpu_reset = 1'b0;
        cpu_en    = (phase_q == 2'd1);
        // Phase 3 is reserved for the fetch read; other phases may patch.
        if (phase_q != 2'd3) begin
          dl_ready = 1'b1;
          if (dl_valid) mem_addr = dl_addr;
        end
      end
      StLoad: begin
        dl_ready = 1'b1;
        if (dl_valid) mem_addr = dl_addr;
        if (dl_end) begin
          state_d = StHold;
          hold_d  = '0;
        end
      end
      StHold: begin
        if (hold_q != HoldLast) hold_d = hold_q + 1'b1;
        if (hold_end) begin
          state_d = StRun;
          dl_done = 1'b1;
        end
      end
      default: state_d = StHold;
    endcase

    if (dl_start) begin
      state_d = StLoad;
      dl_done = 1'b0;
    end
    if (reset) dl_done = 1'b0;

    accept = dl_valid && dl_ready;
    mem_we = accept && in_range;

    // A same-cycle write is accounted on top of the dl_start clear.
    count_base = dl_start ? 12'd0 : count_q;
    sum_base   = dl_start ? 8'd0 : sum_q;
    count_d    = count_base;
    sum_d      = sum_base;
    err_d      = dl_start ? 1'b0 : err_q;
    if (accept) begin
      if (in_range) begin
        if (count_base != 12'hFFF) count_d = count_base + 12'd1;
        sum_d = sum_base + 8'(dl_data);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StHold;
      phase_q    <= 2'd0;
      hold_q     <= '0;
      cpu_data_q <= '0;
      count_q    <= 12'd0;
      sum_q      <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_q + 2'd1;
      hold_q  <= hold_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
      if (state_q == StRun && phase_q == 2'd0) cpu_data_q <= mem_rdata;
    end
  end

  assign cpu_data = cpu_data_q;
  assign dl_count = count_q;
  assign dl_sum   = sum_q;
  assign dl_err   = err_q;

endmodule

// File: tb/tb_rom_load_arbiter.sv
// Directed bench for rom_load_arbiter with a behavioural 1-cycle-latency ROM.
module tb_rom_load_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_data;
  logic          cpu_en, cpu_reset;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata = '0;
  logic          dl_start = 1'b0, dl_end = 1'b0, dl_valid = 1'b0;
  logic [AW-1:0] dl_addr = '0;
  logic [DW-1:0] dl_data = '0;
  logic          dl_ready, dl_done;
  logic [11:0]   dl_count;
  logic [7:0]    dl_sum;
  logic          dl_err;

  logic [7:0]    rom [0:4095];
  logic [1:0]    ph;
  int            n_tests = 0;
  int            n_fail = 0;
  logic [11:0]   exp_count;
  logic [7:0]    exp_sum;

  rom_load_arbiter #(.AW(AW), .DW(DW), .ROM_SIZE(2048), .HOLD(4)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_en(cpu_en),
    .cpu_reset(cpu_reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .dl_start(dl_start), .dl_end(dl_end), .dl_valid(dl_valid),
    .dl_addr(dl_addr), .dl_data(dl_data), .dl_ready(dl_ready), .dl_done(dl_done),
    .dl_count(dl_count), .dl_sum(dl_sum), .dl_err(dl_err)
  );

  always #5 clk = ~clk;

  // Read-first synchronous ROM model.
  initial begin
    logic [7:0] rd;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[5] = 8'hA3;
    rom[6] = 8'h3C;
    forever begin
      @(posedge clk);
      rd = rom[mem_addr];
      if (mem_we) rom[mem_addr] = mem_wdata;
      mem_rdata <= rd;
    end
  end

  task automatic tick();
    @(negedge clk);
    ph = ph + 2'd1;
  endtask

  task automatic wait_release(input logic [1:0] p, input string tag);
    int  exp_n;
    logic seen;
    exp_n = 4;
    for (int n = 4; n <= 7; n++) if (((int'(p) + n) % 4) == 3) exp_n = n;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      #1;
      if (dl_done === 1'b1) begin
        seen = 1'b1;
        n_tests++;
        if (i != exp_n || ph != 2'd3) begin
          n_fail++;
          $display("FAIL %s_done_timing: got cycle %0d phase %0d, want cycle %0d phase 3",
                   tag, i, ph, exp_n);
        end
      end else begin
        n_tests++;
        if (cpu_reset !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_hold_reset: got %b want 1 (cycle %0d)", tag, cpu_reset, i);
        end
      end
      tick();
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_done_timeout: got no dl_done want pulse", tag);
    end
    #1;
    n_tests++;
    if (cpu_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_released: got cpu_reset=%b want 0", tag, cpu_reset);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if ({cpu_reset, cpu_en, mem_we, dl_done, dl_err} !== 5'b10000 || cpu_data !== 8'h00 ||
        dl_count !== 12'd0 || dl_sum !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_values: got rst=%b en=%b we=%b done=%b err=%b data=%h cnt=%0d sum=%h",
               cpu_reset, cpu_en, mem_we, dl_done, dl_err, cpu_data, dl_count, dl_sum);
    end
    reset = 1'b0;
    ph = 2'd0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (cpu_reset !== 1'b1 || dl_done !== (i == 3) || cpu_en !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: cycle %0d got rst=%b done=%b en=%b want rst=1 done=%b en=0",
                 i, cpu_reset, dl_done, cpu_en, i == 3);
      end
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      #1;
      n_tests++;
      if (cpu_reset !== 1'b0 || cpu_en !== (ph == 2'd1)) begin
        n_fail++;
        $display("FAIL reset_cpu_en: phase %0d got rst=%b en=%b want rst=0 en=%b",
                 ph, cpu_reset, cpu_en, ph == 2'd1);
      end
      tick();
    end
  endtask

  task automatic test_fetch();
    while (ph != 2'd3) tick();
    cpu_addr = 12'h005;
    #1;
    n_tests++;
    if (mem_addr !== 12'h005 || mem_we !== 1'b0 || dl_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_slot: got addr=%h we=%b rdy=%b want 005 0 0", mem_addr, mem_we, dl_ready);
    end
    tick();
    tick();
    #1;
    n_tests++;
    if (cpu_data !== 8'hA3 || cpu_en !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_a3: got data=%h en=%b want A3 1", cpu_data, cpu_en);
    end
    tick();
    tick();
    cpu_addr = 12'h006;
    tick();
    tick();
    #1;
    n_tests++;
    if (cpu_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL fetch_3c: got %h want 3C", cpu_data);
    end
  endtask

  task automatic test_download();
    logic [1:0] p;
    logic       rom_ok;
    dl_start = 1'b1;
    tick();
    dl_start = 1'b0;
    exp_count = 12'd0;
    exp_sum = 8'd0;
    #1;
    n_tests++;
    if (cpu_reset !== 1'b1 || dl_ready !== 1'b1 || dl_count !== 12'd0) begin
      n_fail++;
      $display("FAIL load_enter: got rst=%b rdy=%b cnt=%0d want 1 1 0", cpu_reset, dl_ready, dl_count);
    end
    for (int i = 0; i < 16; i++) begin
      dl_valid = 1'b1;
      dl_addr = AW'(i);
      dl_data = 8'h10 + 8'(i);
      exp_count = exp_count + 12'd1;
      exp_sum = exp_sum + dl_data;
      #1;
      n_tests++;
      if (mem_we !== 1'b1 || cpu_en !== 1'b0 || cpu_reset !== 1'b1 || mem_addr !== AW'(i)) begin
        n_fail++;
        $display("FAIL load_write: i=%0d got we=%b en=%b rst=%b addr=%h", i, mem_we, cpu_en,
                 cpu_reset, mem_addr);
      end
      tick();
    end
    dl_valid = 1'b0;
    dl_end = 1'b1;
    p = ph;
    #1;
    n_tests++;
    if (dl_count !== exp_count || dl_sum !== exp_sum || dl_err !== 1'b0) begin
      n_fail++;
      $display("FAIL load_totals: got cnt=%0d sum=%h err=%b want %0d %h 0", dl_count, dl_sum,
               dl_err, exp_count, exp_sum);
    end
    tick();
    dl_end = 1'b0;
    wait_release(p, "load");
    rom_ok = 1'b1;
    for (int i = 0; i < 16; i++) if (rom[i] !== 8'h10 + 8'(i)) rom_ok = 1'b0;
    n_tests++;
    if (!rom_ok) begin
      n_fail++;
      $display("FAIL load_rom: got mismatching ROM bytes at 0x000..0x00F want 0x10..0x1F");
    end
  endtask

  task automatic test_live_patch();
    cpu_addr = 12'h003;
    for (int i = 0; i < 8; i++) begin
      dl_valid = 1'b1;
      dl_addr = 12'h100;
      dl_data = 8'h55;
      #1;
      n_tests++;
      if (ph == 2'd3) begin
        if (dl_ready !== 1'b0 || mem_we !== 1'b0) begin
          n_fail++;
          $display("FAIL patch_phase3: got rdy=%b we=%b want 0 0", dl_ready, mem_we);
        end
      end else begin
        exp_count = exp_count + 12'd1;
        exp_sum = exp_sum + 8'h55;
        if (dl_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h100) begin
          n_fail++;
          $display("FAIL patch_write: phase %0d got rdy=%b we=%b addr=%h", ph, dl_ready, mem_we,
                   mem_addr);
        end
      end
      if (i == 5) begin
        n_tests++;
        if (cpu_data !== 8'h13 || cpu_en !== 1'b1) begin
          n_fail++;
          $display("FAIL patch_fetch: got data=%h en=%b want 13 1", cpu_data, cpu_en);
        end
      end
      tick();
    end
    dl_valid = 1'b0;
    #1;
    n_tests++;
    if (dl_count !== exp_count || dl_sum !== exp_sum || rom[12'h100] !== 8'h55) begin
      n_fail++;
      $display("FAIL patch_totals: got cnt=%0d sum=%h rom=%h want %0d %h 55", dl_count, dl_sum,
               rom[12'h100], exp_count, exp_sum);
    end
    dl_end = 1'b1;
    tick();
    dl_end = 1'b0;
    #1;
    n_tests++;
    if (cpu_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL run_dl_end_ignored: got cpu_reset=%b want 0", cpu_reset);
    end
  endtask

  task automatic test_out_of_range();
    dl_start = 1'b1;
    tick();
    dl_start = 1'b0;
    dl_valid = 1'b1;
    dl_addr = 12'h900;
    dl_data = 8'h77;
    #1;
    n_tests++;
    if (mem_we !== 1'b0 || dl_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_we: got we=%b rdy=%b want 0 1", mem_we, dl_ready);
    end
    tick();
    dl_addr = 12'h020;
    dl_data = 8'h01;
    #1;
    n_tests++;
    if (dl_err !== 1'b1 || dl_count !== 12'd0 || mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_err: got err=%b cnt=%0d we=%b want 1 0 1", dl_err, dl_count, mem_we);
    end
    tick();
    dl_valid = 1'b0;
    #1;
    n_tests++;
    if (dl_count !== 12'd1 || dl_sum !== 8'h01 || dl_err !== 1'b1 || rom[12'h900] !== 8'h00) begin
      n_fail++;
      $display("FAIL oor_after: got cnt=%0d sum=%h err=%b rom900=%h want 1 01 1 00", dl_count,
               dl_sum, dl_err, rom[12'h900]);
    end
    dl_start = 1'b1;
    tick();
    dl_start = 1'b0;
    #1;
    n_tests++;
    if (dl_err !== 1'b0 || dl_count !== 12'd0) begin
      n_fail++;
      $display("FAIL oor_clear: got err=%b cnt=%0d want 0 0", dl_err, dl_count);
    end
  endtask

  task automatic test_restart();
    logic [1:0] p;
    dl_end = 1'b1;
    tick();
    dl_end = 1'b0;
    dl_start = 1'b1;
    dl_valid = 1'b1;
    dl_addr = 12'h030;
    dl_data = 8'h09;
    #1;
    n_tests++;
    if (dl_ready !== 1'b0 || mem_we !== 1'b0 || cpu_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_hold: got rdy=%b we=%b rst=%b want 0 0 1", dl_ready, mem_we, cpu_reset);
    end
    tick();
    dl_start = 1'b0;
    dl_addr = 12'h031;
    dl_data = 8'h21;
    exp_count = 12'd1;
    exp_sum = 8'h21;
    #1;
    n_tests++;
    if (dl_count !== 12'd0 || dl_ready !== 1'b1 || cpu_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_load: got cnt=%0d rdy=%b rst=%b want 0 1 1", dl_count, dl_ready,
               cpu_reset);
    end
    tick();
    dl_addr = 12'h032;
    dl_data = 8'h42;
    exp_count = exp_count + 12'd1;
    exp_sum = exp_sum + 8'h42;
    tick();
    dl_end = 1'b1;
    dl_addr = 12'h033;
    dl_data = 8'h44;
    exp_count = exp_count + 12'd1;
    exp_sum = exp_sum + 8'h44;
    p = ph;
    #1;
    n_tests++;
    if (mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_end_write: got we=%b want 1", mem_we);
    end
    tick();
    dl_end = 1'b0;
    dl_valid = 1'b0;
    #1;
    n_tests++;
    if (dl_count !== exp_count || dl_sum !== exp_sum || dl_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_totals: got cnt=%0d sum=%h rdy=%b want %0d %h 0", dl_count, dl_sum,
               dl_ready, exp_count, exp_sum);
    end
    wait_release(p, "restart");
    n_tests++;
    if (rom[12'h030] !== 8'h00 || rom[12'h033] !== 8'h44) begin
      n_fail++;
      $display("FAIL restart_rom: got rom030=%h rom033=%h want 00 44", rom[12'h030], rom[12'h033]);
    end
  endtask

  initial begin
    ph = 2'd0;
    test_reset();
    test_fetch();
    test_download();
    test_live_patch();
    test_out_of_range();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
